// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running W-bit counter, with period-aligned duty updates.
// Optional sequence checker on the count bus is built when COUNT_PWM_ERRCHK_EN is defined.
module count_pwm_gen #(
  parameter int W        = 3,
  parameter int DUTY_RST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] count,
  input  logic [W:0]   duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         pwm,
  output logic         period_done,
  output logic [W:0]   active_duty,
  output logic         err_seq
);

  localparam logic [W:0]   DUTY_MAX   = {1'b1, {W{1'b0}}};
  localparam logic [W-1:0] CNT_MAX    = {W{1'b1}};
  localparam logic [W:0]   DUTY_RST_V = DUTY_RST[W:0];

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] prev_count;
  logic [W:0]   pend_duty;
  logic         pend_valid;
  logic         wrap;
  logic         at_zero;
  logic         boundary;
  logic         apply_pend;
  logic         accept;
  logic [W:0]   eff_duty;
  logic         pwm_nxt;

  function automatic logic [W:0] sat_duty(input logic [W:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  assign at_zero    = (count == '0);
  assign wrap       = (prev_count == CNT_MAX) && at_zero;
  // Any arrival at zero counts as a boundary, including an upstream counter reset.
  assign boundary   = en && at_zero && ((state == RUN) || (state == SYNC));
  assign apply_pend = pend_valid && (boundary || (state == IDLE));
  assign eff_duty   = (boundary && pend_valid) ? pend_duty : active_duty;
  assign duty_ready = ~pend_valid;
  assign accept     = duty_valid && duty_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SYNC;
        SYNC:    if (at_zero) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    pwm_nxt = 1'b0;
    case (state)
      SYNC:    if (en && at_zero) pwm_nxt = ({1'b0, count} < eff_duty);
      RUN:     if (en) pwm_nxt = ({1'b0, count} < eff_duty);
      default: pwm_nxt = 1'b0;
    endcase
  end

  // Output register stage: pwm trails the sampled count by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm         <= 1'b0;
      period_done <= 1'b0;
      prev_count  <= '0;
    end else begin
      pwm         <= pwm_nxt;
      period_done <= (state == RUN) && wrap;
      prev_count  <= count;
    end
  end

  // accept and apply_pend are mutually exclusive: one needs the slot empty, the other full.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_duty <= DUTY_RST_V;
      pend_valid  <= 1'b0;
    end else begin
      if (apply_pend) begin
        active_duty <= pend_duty;
        pend_valid  <= 1'b0;
      end
      if (accept) pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pend_duty <= sat_duty(duty_in);
  end

`ifdef COUNT_PWM_ERRCHK_EN
  logic         run_p1;
  logic [W-1:0] count_exp;

  assign count_exp = prev_count + 1'b1;

  // The first RUN cycle is skipped so the SYNC->RUN hand-over is never flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_p1  <= 1'b0;
      err_seq <= 1'b0;
    end else begin
      run_p1 <= (state == RUN);
      if ((state == RUN) && run_p1 && (count != count_exp)) err_seq <= 1'b1;
    end
  end
`else
  assign err_seq = 1'b0;
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen (W=3): a behavioural model pushes expected outputs per
// driven cycle into a scoreboard queue; outputs are popped and checked 1 time unit after the edge.
module tb_count_pwm_gen;
  localparam int W = 3;
`ifdef COUNT_PWM_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] count;
  logic [W:0]   duty_in;
  logic         duty_valid;
  logic         duty_ready;
  logic         pwm;
  logic         period_done;
  logic [W:0]   active_duty;
  logic         err_seq;

  count_pwm_gen #(.W(W), .DUTY_RST(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .count       (count),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm         (pwm),
    .period_done (period_done),
    .active_duty (active_duty),
    .err_seq     (err_seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pwm;
    logic       pd;
    logic [W:0] act;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int hi_cnt   = 0;
  int pd_cnt   = 0;
  int cnt      = 0;

  // Model state: 0 = IDLE, 1 = SYNC, 2 = RUN
  int m_st     = 0;
  int m_active = 0;
  int m_pend   = 0;
  int m_prev   = 0;
  bit m_pv     = 1'b0;
  bit m_err    = 1'b0;
  bit m_ran    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  task automatic step(input int c);
    exp_t e;
    bit   acc;
    bit   wrap;
    bit   bnd;
    int   eff;
    count = c[W-1:0];
    acc   = !rst && duty_valid && !m_pv;
    if (rst) begin
      m_st = 0; e.pwm = 0; e.pd = 0; m_active = 0; m_pv = 0;
      m_err = 0; m_prev = 0; m_ran = 0;
    end else begin
      wrap  = (m_prev == 7) && (c == 0);
      e.pd  = (m_st == 2) && wrap;
      bnd   = en && (c == 0) && (m_st != 0);
      eff   = (bnd && m_pv) ? m_pend : m_active;
      e.pwm = en && ((m_st == 2) || ((m_st == 1) && (c == 0))) && (c < eff);
      if (ERRCHK && (m_st == 2) && m_ran && (c != ((m_prev + 1) % 8))) m_err = 1;
      m_ran = (m_st == 2);
      if ((bnd || (m_st == 0)) && m_pv) begin
        m_active = m_pend;
        m_pv     = 0;
      end
      if (acc) begin
        m_pend = (duty_in > 8) ? 8 : int'(duty_in);
        m_pv   = 1;
      end
      if (!en)            m_st = 0;
      else if (m_st == 0) m_st = 1;
      else if (m_st == 1) m_st = (c == 0) ? 2 : 1;
      m_prev = c;
    end
    e.act = m_active[W:0];
    e.rdy = !m_pv;
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pwm",         pwm,         e.pwm);
    chk("period_done", period_done, e.pd);
    chk("active_duty", active_duty, e.act);
    chk("duty_ready",  duty_ready,  e.rdy);
    chk("err_seq",     err_seq,     e.err);
    hi_cnt += int'(pwm);
    pd_cnt += int'(period_done);
    if (acc) duty_valid = 1'b0;
  endtask

  task automatic tick();
    step(cnt);
    cnt = (cnt + 1) % 8;
  endtask

  task automatic offer(input int d);
    duty_in    = d[W:0];
    duty_valid = 1'b1;
  endtask

  task automatic align();
    for (int i = 0; i < 8 && cnt != 0; i++) tick();
  endtask

  task automatic window(input int exp_hi, input int exp_pd);
    hi_cnt = 0;
    pd_cnt = 0;
    repeat (8) tick();
    chk("high_clocks", hi_cnt, exp_hi);
    chk("period_pulses", pd_cnt, exp_pd);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; duty_valid = 1'b0; duty_in = '0; count = '0;
    repeat (3) step(0);
    chk("reset_pwm", pwm, 1'b0);
    chk("reset_ready", duty_ready, 1'b1);

    // Load duty 3 while idle, then start
    rst = 1'b0; cnt = 1;
    offer(3);
    tick();
    tick();
    chk("idle_apply", active_duty, 3);
    en = 1'b1;
    align();
    window(3, 0);
    window(3, 1);
    window(3, 1);

    // Mid-period update to 6 waits for the next boundary
    hi_cnt = 0;
    repeat (4) tick();
    offer(6);
    repeat (4) tick();
    chk("mid_update_old_period", hi_cnt, 3);
    chk("mid_update_ready", duty_ready, 1'b0);
    window(6, 1);

    // Clamp 9 -> 8, then duty 0
    hi_cnt = 0;
    repeat (2) tick();
    offer(9);
    repeat (6) tick();
    chk("pre_full_period", hi_cnt, 6);
    window(8, 1);
    chk("clamped_duty", active_duty, 8);
    hi_cnt = 0;
    repeat (3) tick();
    offer(0);
    repeat (5) tick();
    chk("pre_zero_period", hi_cnt, 8);
    window(0, 1);

    // Handshake on the boundary cycle applies one period later
    offer(3);
    window(0, 1);

    // Disable at count 2, re-enable mid-period
    hi_cnt = 0;
    repeat (2) tick();
    en = 1'b0;
    tick();
    chk("disable_hi", hi_cnt, 2);
    repeat (2) tick();
    en = 1'b1;
    repeat (3) tick();
    chk("resync_hi", hi_cnt, 2);
    window(3, 0);

    // Count skips 5 -> 7 while running
    repeat (6) tick();
    cnt = 7;
    tick();
    chk("err_after_skip", err_seq, ERRCHK);
    tick();
    chk("err_held", err_seq, ERRCHK);
    window(3, 1);

    // Upstream counter reset mid-period acts as a boundary without a period pulse
    tick();
    offer(5);
    repeat (3) tick();
    cnt = 0;
    hi_cnt = 0;
    pd_cnt = 0;
    tick();
    chk("urst_no_pulse", pd_cnt, 0);
    chk("urst_duty", active_duty, 5);
    repeat (7) tick();
    chk("urst_period_hi", hi_cnt, 5);
    window(5, 1);

    // Reset again mid-run
    rst = 1'b1;
    step(0);
    chk("rerst_duty", active_duty, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
